u_mem_arb: RTL and testbench
============================

U_MEM_ARB -- requirements
Module: u_mem_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive LSU wins allowed while the IFU waits.
REQ-002 SHALL have parameter TMO_CYC, default 255: cycles before an unanswered transaction is aborted.
REQ-003 SHALL have ports:
  clk        in   1   clock, rising edge
  rstn       in   1   reset, asynchronous, active-low
  if_req     in   1   IFU fetch request, level, held until if_vld
  if_adr     in   32  IFU word address
  if_gnt     out  1   one-cycle pulse, IFU request accepted
  if_vld     out  1   one-cycle pulse, fetch complete
  if_rd      out  32  fetch data, valid with if_vld
  if_err     out  1   timeout flag, valid with if_vld
  lsu_a      in   32  LSU address
  lsu_we     in   4   LSU write byte enables
  lsu_wd     in   32  LSU write data
  lsu_re     in   4   LSU read byte enables
  lsu_vld    out  1   one-cycle pulse, LSU access complete
  lsu_rd     out  32  load data, valid with lsu_vld
  lsu_err    out  1   timeout flag, valid with lsu_vld
  mem_req    out  1   memory address phase request
  mem_adr    out  32  memory address
  mem_we     out  4   memory write byte enables
  mem_wd     out  32  memory write data
  mem_re     out  4   memory read byte enables
  mem_gnt    in   1   memory accepted the address phase
  mem_rvld   in   1   memory response or write acknowledge
  mem_rdata  in   32  memory read data

Function
REQ-004 SHALL treat the LSU as requesting when |lsu_we or |lsu_re is true. The LSU holds its request until lsu_vld.
REQ-005 SHALL use the FSM states IDLE, ADDR, DATA and RESP, with exactly one transaction outstanding at a time.
REQ-006 SHALL arbitrate only in IDLE, by fixed priority:
  - LSU wins over IFU.
  - Exception: IFU wins when starve_cnt == STARVE_MAX.
REQ-007 SHALL update starve_cnt (saturating) at each grant:
  - +1 when the LSU is granted while if_req=1.
  - Cleared when the IFU is granted.
REQ-008 SHALL, on a grant:
  - record the owner;
  - latch the address, write enables, write data and read enables into registers;
  - go IDLE->ADDR.
  The mem_* outputs SHALL be driven only from these registers.
REQ-009 SHALL, for an IFU grant, present mem_we=0 and mem_re=4'b1111.
REQ-010 SHALL, when an LSU request has both lsu_we and lsu_re nonzero, perform a write with mem_re=0.
REQ-011 SHALL pulse if_gnt in the cycle the IFU grant is decided in IDLE.
REQ-012 SHALL hold mem_req=1 in ADDR only, moving ADDR->DATA on the first cycle mem_gnt=1.
REQ-013 SHALL, in DATA on mem_rvld=1:
  - register mem_rdata into the owner's rd output;
  - go to RESP.
  mem_rvld outside DATA SHALL be ignored, including late responses after a timeout.
REQ-014 SHALL, in RESP (one cycle), pulse the owner's vld, then go RESP->IDLE. Minimum latency is 4 cycles from a request sampled in IDLE to vld.
REQ-015 SHALL keep an rd output stable between responses and SHALL never assert if_vld and lsu_vld together.
REQ-016 SHALL run a timeout counter in ADDR and DATA, cleared on entry to ADDR. When the counter reaches TMO_CYC:
  - drop mem_req;
  - set rd=0 and err=1 for the owner;
  - go to RESP.
REQ-017 SHALL give mem_rvld/mem_gnt priority over timeout when both occur in the same cycle.

Reset
REQ-018 SHALL, while rstn=0, force:
  - state IDLE, starve_cnt 0, timeout counter 0;
  - every output and latched register to 0.
REQ-019 SHALL abandon any in-flight transaction on reset without issuing vld. mem_req SHALL fall asynchronously with rstn.

Structure
REQ-020 SHALL place the state enum arb_st_t and the owner enum arb_own_t in the shared package rv_pkg.
REQ-021 SHALL implement the timeout counter as the sub-module u_tmo_cnt, with inputs clr, en and parameter TMO_CYC, and output expired.

Verification
REQ-022 IFU-only read: if_req=1, if_adr=0x100, mem_gnt on the first ADDR cycle, mem_rvld one cycle later with mem_rdata=0xDEADBEEF -> if_gnt pulse, then if_vld with if_rd=0xDEADBEEF, if_err=0, 4 cycles after the request.
REQ-023 Simultaneous requests: if_req=1 with LSU store lsu_we=4'b1111 at 0x200 -> LSU served first with mem_we=4'b1111; IFU served next.
REQ-024 Starvation: IFU held, LSU re-requesting continuously -> after 4 LSU grants the 5th grant goes to the IFU and starve_cnt returns to 0.
REQ-025 Timeout: TMO_CYC=8, mem_gnt never asserted -> after 8 ADDR cycles mem_req drops and lsu_vld=1, lsu_err=1, lsu_rd=0; a later mem_rvld causes no vld.
REQ-026 Reset mid-DATA: assert rstn=0 while waiting for mem_rvld -> all outputs 0 immediately; after release the arbiter is in IDLE and re-arbitrates the held requests.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner tags and the
// latched memory command.
package rv_pkg;

   localparam int unsigned ADR_W = 32;
   localparam int unsigned DAT_W = 32;
   localparam int unsigned BE_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      RESP
   } arb_st_t;

   typedef enum logic {
      OWN_IFU,
      OWN_LSU
   } arb_own_t;

   typedef struct packed {
      logic [ADR_W-1:0] adr;
      logic [BE_W-1:0]  we;
      logic [DAT_W-1:0] wd;
      logic [BE_W-1:0]  re;
   } mem_cmd_t;

endpackage

// File: rtl/u_tmo_cnt.sv
// Transaction watchdog: counts enabled cycles since clr and flags the cycle
// on which the TMO_CYC-th enabled cycle is reached.
module u_tmo_cnt #(
   parameter int unsigned TMO_CYC = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter parks on its last value so expiry stays asserted until cleared.
   assign expired = en && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/u_mem_arb.sv
// Single-outstanding memory arbiter between instruction fetch (IFU) and
// load/store (LSU), LSU-priority with IFU anti-starvation and a response timeout.
module u_mem_arb
   import rv_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TMO_CYC    = 255
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             if_req,
   input  logic [ADR_W-1:0] if_adr,
   output logic             if_gnt,
   output logic             if_vld,
   output logic [DAT_W-1:0] if_rd,
   output logic             if_err,
   input  logic [ADR_W-1:0] lsu_a,
   input  logic [BE_W-1:0]  lsu_we,
   input  logic [DAT_W-1:0] lsu_wd,
   input  logic [BE_W-1:0]  lsu_re,
   output logic             lsu_vld,
   output logic [DAT_W-1:0] lsu_rd,
   output logic             lsu_err,
   output logic             mem_req,
   output logic [ADR_W-1:0] mem_adr,
   output logic [BE_W-1:0]  mem_we,
   output logic [DAT_W-1:0] mem_wd,
   output logic [BE_W-1:0]  mem_re,
   input  logic             mem_gnt,
   input  logic             mem_rvld,
   input  logic [DAT_W-1:0] mem_rdata
);

   localparam int unsigned SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

   arb_st_t          state_q, state_d;
   arb_own_t         own_q, own_d;
   mem_cmd_t         cmd_q, cmd_d;
   logic [SC_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic             mem_req_q, mem_req_d;
   logic             if_gnt_q, if_gnt_d;
   logic             if_vld_q, if_vld_d;
   logic             if_err_q, if_err_d;
   logic [DAT_W-1:0] if_rd_q, if_rd_d;
   logic             lsu_vld_q, lsu_vld_d;
   logic             lsu_err_q, lsu_err_d;
   logic [DAT_W-1:0] lsu_rd_q, lsu_rd_d;

   logic             lsu_req;
   logic             grant;
   logic             tmo_en;
   logic             tmo_exp;
   logic             rsp_go;
   logic             rsp_err;
   logic [DAT_W-1:0] rsp_data;

   assign lsu_req = (|lsu_we) || (|lsu_re);
   assign tmo_en  = (state_q == ADDR) || (state_q == DATA);

   u_tmo_cnt #(
      .TMO_CYC (TMO_CYC)
   ) u_tmo (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (grant),
      .en      (tmo_en),
      .expired (tmo_exp)
   );

   always_comb begin
      state_d      = state_q;
      own_d        = own_q;
      cmd_d        = cmd_q;
      starve_cnt_d = starve_cnt_q;
      if_gnt_d     = 1'b0;
      if_vld_d     = 1'b0;
      lsu_vld_d    = 1'b0;
      if_rd_d      = if_rd_q;
      if_err_d     = if_err_q;
      lsu_rd_d     = lsu_rd_q;
      lsu_err_d    = lsu_err_q;
      grant        = 1'b0;
      rsp_go       = 1'b0;
      rsp_err      = 1'b0;
      rsp_data     = '0;

      case (state_q)
         IDLE: begin
            if (if_req && (!lsu_req || (starve_cnt_q == SC_MAX))) begin
               grant        = 1'b1;
               own_d        = OWN_IFU;
               cmd_d.adr    = if_adr;
               cmd_d.we     = '0;
               cmd_d.wd     = '0;
               cmd_d.re     = '1;
               starve_cnt_d = '0;
               if_gnt_d     = 1'b1;
               state_d      = ADDR;
            end else if (lsu_req) begin
               grant     = 1'b1;
               own_d     = OWN_LSU;
               cmd_d.adr = lsu_a;
               cmd_d.we  = lsu_we;
               cmd_d.wd  = lsu_wd;
               // A combined write+read request is performed as a pure write.
               cmd_d.re  = (|lsu_we) ? BE_W'(0) : lsu_re;
               if (if_req && (starve_cnt_q != SC_MAX)) begin
                  starve_cnt_d = starve_cnt_q + SC_W'(1);
               end
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (mem_gnt) begin
               state_d = DATA;
            end else if (tmo_exp) begin
               rsp_go  = 1'b1;
               rsp_err = 1'b1;
            end
         end
         DATA: begin
            if (mem_rvld) begin
               rsp_go   = 1'b1;
               rsp_data = mem_rdata;
            end else if (tmo_exp) begin
               rsp_go  = 1'b1;
               rsp_err = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Completion (data or timeout) is steered to whoever owns the transaction.
      if (rsp_go) begin
         state_d = RESP;
         if (own_q == OWN_IFU) begin
            if_vld_d = 1'b1;
            if_rd_d  = rsp_data;
            if_err_d = rsp_err;
         end else begin
            lsu_vld_d = 1'b1;
            lsu_rd_d  = rsp_data;
            lsu_err_d = rsp_err;
         end
      end

      mem_req_d = (state_d == ADDR);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         own_q        <= OWN_IFU;
         cmd_q        <= '0;
         starve_cnt_q <= '0;
         mem_req_q    <= 1'b0;
         if_gnt_q     <= 1'b0;
         if_vld_q     <= 1'b0;
         if_rd_q      <= '0;
         if_err_q     <= 1'b0;
         lsu_vld_q    <= 1'b0;
         lsu_rd_q     <= '0;
         lsu_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         own_q        <= own_d;
         cmd_q        <= cmd_d;
         starve_cnt_q <= starve_cnt_d;
         mem_req_q    <= mem_req_d;
         if_gnt_q     <= if_gnt_d;
         if_vld_q     <= if_vld_d;
         if_rd_q      <= if_rd_d;
         if_err_q     <= if_err_d;
         lsu_vld_q    <= lsu_vld_d;
         lsu_rd_q     <= lsu_rd_d;
         lsu_err_q    <= lsu_err_d;
      end
   end

   assign if_gnt  = if_gnt_q;
   assign if_vld  = if_vld_q;
   assign if_rd   = if_rd_q;
   assign if_err  = if_err_q;
   assign lsu_vld = lsu_vld_q;
   assign lsu_rd  = lsu_rd_q;
   assign lsu_err = lsu_err_q;
   assign mem_req = mem_req_q;
   assign mem_adr = cmd_q.adr;
   assign mem_we  = cmd_q.we;
   assign mem_wd  = cmd_q.wd;
   assign mem_re  = cmd_q.re;

endmodule

// File: tb/tb_u_mem_arb.sv
// Self-checking bench for u_mem_arb: transaction-level model of arbitration,
// timeout and response timing, checked against the DUT on every negedge.
module tb_u_mem_arb;

   localparam int TMO  = 8;
   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        if_req;
   logic [31:0] if_adr;
   logic        if_gnt, if_vld, if_err;
   logic [31:0] if_rd;
   logic [31:0] lsu_a, lsu_wd;
   logic [3:0]  lsu_we, lsu_re;
   logic        lsu_vld, lsu_err;
   logic [31:0] lsu_rd;
   logic        mem_req;
   logic [31:0] mem_adr, mem_wd;
   logic [3:0]  mem_we, mem_re;
   logic        mem_gnt, mem_rvld;
   logic [31:0] mem_rdata;

   u_mem_arb #(.STARVE_MAX(SMAX), .TMO_CYC(TMO)) dut (
      .clk(clk), .rstn(rstn),
      .if_req(if_req), .if_adr(if_adr), .if_gnt(if_gnt), .if_vld(if_vld),
      .if_rd(if_rd), .if_err(if_err),
      .lsu_a(lsu_a), .lsu_we(lsu_we), .lsu_wd(lsu_wd), .lsu_re(lsu_re),
      .lsu_vld(lsu_vld), .lsu_rd(lsu_rd), .lsu_err(lsu_err),
      .mem_req(mem_req), .mem_adr(mem_adr), .mem_we(mem_we), .mem_wd(mem_wd),
      .mem_re(mem_re), .mem_gnt(mem_gnt), .mem_rvld(mem_rvld), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Expected DUT outputs for the current cycle
   logic        exp_if_gnt, exp_if_vld, exp_lsu_vld, exp_mem_req;
   logic        exp_if_err, exp_lsu_err;
   logic [31:0] exp_if_rd, exp_lsu_rd, exp_adr, exp_wd;
   logic [3:0]  exp_we, exp_re;

   // Requester / arbitration model state
   bit          if_pend, lsu_pend, own_ifu, late_rvld;
   logic [31:0] m_if_adr, m_lsu_a, m_lsu_wd;
   logic [3:0]  m_lsu_we, m_lsu_re;
   int          starve;
   bit          obs_ifu;
   logic [3:0]  obs_we;
   int          obs_req_cyc;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("if_gnt",  32'(if_gnt),  32'(exp_if_gnt));
         chk("if_vld",  32'(if_vld),  32'(exp_if_vld));
         chk("lsu_vld", 32'(lsu_vld), 32'(exp_lsu_vld));
         chk("mem_req", 32'(mem_req), 32'(exp_mem_req));
         chk("if_rd",   if_rd,  exp_if_rd);
         chk("lsu_rd",  lsu_rd, exp_lsu_rd);
         if (exp_mem_req) begin
            chk("mem_adr", mem_adr, exp_adr);
            chk("mem_we",  32'(mem_we), 32'(exp_we));
            chk("mem_re",  32'(mem_re), 32'(exp_re));
            chk("mem_wd",  mem_wd, exp_wd);
         end
         if (exp_if_vld)  chk("if_err",  32'(if_err),  32'(exp_if_err));
         if (exp_lsu_vld) chk("lsu_err", 32'(lsu_err), 32'(exp_lsu_err));
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_defaults();
      exp_if_gnt  = 1'b0;
      exp_if_vld  = 1'b0;
      exp_lsu_vld = 1'b0;
      exp_mem_req = 1'b0;
      mem_gnt     = 1'b0;
      mem_rvld    = late_rvld | ($urandom_range(0, 3) == 0);
      mem_rdata   = $urandom;
   endtask

   task automatic drive_req();
      if_req = if_pend;
      if_adr = if_pend ? m_if_adr : $urandom;
      lsu_a  = m_lsu_a;
      lsu_wd = m_lsu_wd;
      lsu_we = lsu_pend ? m_lsu_we : 4'h0;
      lsu_re = lsu_pend ? m_lsu_re : 4'h0;
   endtask

   task automatic new_lsu(input logic [31:0] a);
      int kind;
      kind     = $urandom_range(0, 2);
      lsu_pend = 1'b1;
      m_lsu_a  = a;
      m_lsu_wd = $urandom;
      m_lsu_we = (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      m_lsu_re = (kind == 1) ? 4'h0 : 4'($urandom_range(1, 15));
   endtask

   // One arbitration round: IDLE, ADDR cycles until gnt/timeout, DATA cycles
   // until rvld/timeout, then RESP. g/r are memory wait cycles.
   task automatic do_round(input int g, input int r, input logic [31:0] data, input bit rst_mid);
      int  a, d, lim;
      bit  gnt_ok, ok;
      cyc_defaults();
      drive_req();
      if (!if_pend && !lsu_pend) begin
         next_cyc();
         return;
      end
      own_ifu = if_pend && (!lsu_pend || starve == SMAX);
      if (own_ifu) starve = 0;
      else if (if_pend && starve < SMAX) starve++;
      if (own_ifu) begin
         exp_adr = m_if_adr; exp_we = 4'h0; exp_wd = 32'h0; exp_re = 4'hF;
      end else begin
         exp_adr = m_lsu_a; exp_we = m_lsu_we; exp_wd = m_lsu_wd;
         exp_re  = (m_lsu_we != 4'h0) ? 4'h0 : m_lsu_re;
      end
      next_cyc();

      gnt_ok = (g + 1 <= TMO);
      a      = gnt_ok ? g + 1 : TMO;
      lim    = (a + 1 > TMO) ? a + 1 : TMO;
      ok     = gnt_ok && (a + r + 1 <= lim);
      d      = !gnt_ok ? 0 : (ok ? r + 1 : lim - a);
      obs_req_cyc = 0;

      for (int j = 1; j <= a; j++) begin
         cyc_defaults();
         exp_mem_req = 1'b1;
         exp_if_gnt  = (j == 1) && own_ifu;
         mem_gnt     = (j == g + 1);
         if (j == 1) begin
            obs_ifu = if_gnt;
            obs_we  = mem_we;
         end
         obs_req_cyc += int'(mem_req);
         next_cyc();
      end
      for (int j = 1; j <= d; j++) begin
         cyc_defaults();
         mem_rvld = ok && (j == r + 1);
         if (mem_rvld) mem_rdata = data;
         if (rst_mid) begin
            chk_en = 1'b0;
            rstn   = 1'b0;
            #1;
            chk("rst_mem_req", 32'(mem_req), 32'h0);
            chk("rst_mem_adr", mem_adr, 32'h0);
            chk("rst_mem_we",  32'(mem_we), 32'h0);
            chk("rst_mem_re",  32'(mem_re), 32'h0);
            chk("rst_mem_wd",  mem_wd, 32'h0);
            chk("rst_if_rd",   if_rd, 32'h0);
            chk("rst_lsu_rd",  lsu_rd, 32'h0);
            repeat (2) next_cyc();
            chk("rst_hold_vld", 32'({if_vld, lsu_vld, if_gnt, mem_req}), 32'h0);
            rstn       = 1'b1;
            starve     = 0;
            exp_if_rd  = 32'h0;
            exp_lsu_rd = 32'h0;
            chk_en     = 1'b1;
            return;
         end
         obs_req_cyc += int'(mem_req);
         next_cyc();
      end

      cyc_defaults();
      if (own_ifu) begin
         exp_if_vld = 1'b1; exp_if_rd = ok ? data : 32'h0; exp_if_err = !ok; if_pend = 1'b0;
      end else begin
         exp_lsu_vld = 1'b1; exp_lsu_rd = ok ? data : 32'h0; exp_lsu_err = !ok; lsu_pend = 1'b0;
      end
      next_cyc();
   endtask

   initial begin
      rstn = 1'b0; if_req = 1'b0; if_adr = '0; lsu_a = '0; lsu_we = '0; lsu_wd = '0;
      lsu_re = '0; mem_gnt = 1'b0; mem_rvld = 1'b0; mem_rdata = '0;
      if_pend = 1'b0; lsu_pend = 1'b0; late_rvld = 1'b0; starve = 0;
      m_if_adr = '0; m_lsu_a = '0; m_lsu_wd = '0; m_lsu_we = '0; m_lsu_re = '0;
      exp_if_rd = '0; exp_lsu_rd = '0; exp_if_err = 1'b0; exp_lsu_err = 1'b0;
      exp_adr = '0; exp_we = '0; exp_wd = '0; exp_re = '0;
      exp_if_gnt = 1'b0; exp_if_vld = 1'b0; exp_lsu_vld = 1'b0; exp_mem_req = 1'b0;

      // Reset state
      repeat (3) next_cyc();
      chk("reset_outs", 32'({if_gnt, if_vld, if_err, lsu_vld, lsu_err, mem_req}), 32'h0);
      chk("reset_if_rd", if_rd, 32'h0);
      chk("reset_lsu_rd", lsu_rd, 32'h0);
      chk("reset_mem_adr", mem_adr, 32'h0);
      chk("reset_mem_be", 32'({mem_we, mem_re}), 32'h0);
      rstn   = 1'b1;
      chk_en = 1'b1;

      // IFU-only read
      if_pend = 1'b1; m_if_adr = 32'h100;
      do_round(0, 0, 32'hDEADBEEF, 1'b0);
      chk("lit_ifu_gnt", 32'(obs_ifu), 32'h1);
      chk("lit_ifu_rd", if_rd, 32'hDEADBEEF);
      chk("lit_ifu_req_cyc", 32'(obs_req_cyc), 32'h1);

      // Simultaneous: LSU store first, then IFU
      if_pend = 1'b1; m_if_adr = 32'h300;
      lsu_pend = 1'b1; m_lsu_a = 32'h200; m_lsu_we = 4'hF; m_lsu_re = 4'h0; m_lsu_wd = 32'h1234_5678;
      do_round(1, 0, $urandom, 1'b0);
      chk("lit_sim_first_lsu", 32'(obs_ifu), 32'h0);
      chk("lit_sim_we", 32'(obs_we), 32'hF);
      do_round(0, 1, $urandom, 1'b0);
      chk("lit_sim_then_ifu", 32'(obs_ifu), 32'h1);

      // Starvation: four LSU wins, then IFU, then LSU again
      if_pend = 1'b1; m_if_adr = 32'h400;
      for (int k = 0; k < 5; k++) begin
         if (!lsu_pend) new_lsu(32'h1000 + 32'(k));
         do_round(0, 0, $urandom, 1'b0);
         chk("lit_starve_owner", 32'(obs_ifu), (k == 4) ? 32'h1 : 32'h0);
      end
      if_pend = 1'b1;
      if (!lsu_pend) new_lsu(32'h2000);
      do_round(0, 0, $urandom, 1'b0);
      chk("lit_starve_cleared", 32'(obs_ifu), 32'h0);

      // Timeout in ADDR with late responses afterwards
      if_pend = 1'b0;
      lsu_pend = 1'b1; m_lsu_a = 32'h3000; m_lsu_we = 4'h0; m_lsu_re = 4'hF;
      late_rvld = 1'b1;
      do_round(1000, 0, $urandom, 1'b0);
      chk("lit_tmo_req_cyc", 32'(obs_req_cyc), 32'(TMO));
      chk("lit_tmo_err", 32'(lsu_err), 32'h1);
      chk("lit_tmo_rd", lsu_rd, 32'h0);
      do_round(0, 0, $urandom, 1'b0);
      do_round(0, 0, $urandom, 1'b0);
      late_rvld = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         int g, r;
         if (!if_pend && $urandom_range(0, 2) != 0) begin
            if_pend = 1'b1; m_if_adr = $urandom;
         end
         if (!lsu_pend && $urandom_range(0, 2) != 0) new_lsu($urandom);
         g = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 2);
         r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 2);
         do_round(g, r, $urandom, 1'b0);
      end

      // Reset while waiting in DATA, then re-arbitration of held requests
      if_pend = 1'b1; m_if_adr = 32'h0000_0600;
      lsu_pend = 1'b1; m_lsu_a = 32'h0000_0500; m_lsu_we = 4'h0; m_lsu_re = 4'h3;
      m_lsu_wd = 32'h0;
      do_round(0, 5, $urandom, 1'b1);
      do_round(0, 0, 32'hCAFE_F00D, 1'b0);
      chk("lit_rst_rearb_lsu", 32'(obs_ifu), 32'h0);
      chk("lit_rst_rearb_rd", lsu_rd, 32'hCAFE_F00D);
      do_round(0, 0, 32'h0BAD_F00D, 1'b0);
      chk("lit_rst_rearb_ifu", 32'(obs_ifu), 32'h1);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
